// File: rtl/ibuf_route_pkg.sv
// Shared definitions for the router input-port unit: port codes, flit types, FSM states.
// The IBUF_ERRCHK_EN build option adds flit-type checking in ibuf_route.
package ibuf_route_pkg;

    localparam int unsigned PORT  = 5;
    localparam int unsigned PORTW = $clog2(PORT) - 1;

    localparam logic [PORTW:0] P_LOCAL = 3'd0;
    localparam logic [PORTW:0] P_NORTH = 3'd1;
    localparam logic [PORTW:0] P_EAST  = 3'd2;
    localparam logic [PORTW:0] P_SOUTH = 3'd3;
    localparam logic [PORTW:0] P_WEST  = 3'd4;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_XFER  = 2'd2
    } state_e;

endpackage

// File: rtl/ibuf_route_if.sv
// Link, request/grant and crossbar signals of one router input port.
// The err pulse is present only when IBUF_ERRCHK_EN is defined.
interface ibuf_route_if
    import ibuf_route_pkg::*;
#(
    parameter int unsigned DATAW = 16
);
    logic [DATAW-1:0] in_data;
    logic             in_vld;
    logic             in_rdy;
    logic [PORTW:0]   port;
    logic             req;
    logic             grt;
    logic [DATAW-1:0] dout;
    logic             dvalid;
    logic             out_rdy;
`ifdef IBUF_ERRCHK_EN
    logic             err;
`endif

    modport slave (
        input  in_data, in_vld, grt, out_rdy,
        output in_rdy, port, req, dout, dvalid
`ifdef IBUF_ERRCHK_EN
        , err
`endif
    );

    modport master (
        output in_data, in_vld, grt, out_rdy,
        input  in_rdy, port, req, dout, dvalid
`ifdef IBUF_ERRCHK_EN
        , err
`endif
    );

endinterface

// File: rtl/ibuf_fifo.sv
// Synchronous power-of-2 FIFO with full/empty flags and occupancy count.
// Unaffected by IBUF_ERRCHK_EN.
module ibuf_fifo #(
    parameter int unsigned DATAW = 16,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTRW = $clog2(DEPTH),
    localparam int unsigned CNTW = PTRW + 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic [DATAW-1:0] wdata,
    input  logic             pop,
    output logic [DATAW-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNTW-1:0]  count
);

    logic [DATAW-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_q;
    logic [PTRW-1:0]  rd_q;
    logic [CNTW-1:0]  cnt_q;

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst_) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PTRW'(1);
            if (pop)  rd_q <= rd_q + PTRW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNTW'(1);
                2'b01:   cnt_q <= cnt_q - CNTW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= wdata;
    end

    assign rdata = mem[rd_q];
    assign full  = (cnt_q == CNTW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

    occupancy_consistent: assert property (@(posedge clk) disable iff (rst_)
        (empty == (count == '0)) && (count <= CNTW'(DEPTH)));

endmodule

// File: rtl/ibuf_route.sv
// Router input port: flit FIFO, XY route compute on head flits, wormhole request/drain FSM.
// Define IBUF_ERRCHK_EN to drop out-of-order flit types and pulse err.
module ibuf_route
    import ibuf_route_pkg::*;
#(
    parameter int unsigned DATAW = 16,
    parameter int unsigned ADDRW = 2,
    parameter int unsigned MYX   = 0,
    parameter int unsigned MYY   = 0,
    parameter int unsigned DEPTH = 4
) (
    input logic          clk,
    input logic          rst_,
    ibuf_route_if.slave  bus
);

    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    logic [DATAW-1:0] head;
    logic             full;
    logic             empty;
    logic [CNTW-1:0]  count;
    logic             push;
    logic             pop;
    logic             drop;
    logic             dvalid_c;
    logic             is_head;
    logic             is_tail;
    flit_type_e       head_t;
    state_e           state_q, state_d;
    logic [PORTW:0]   port_q, port_d;

    assign push = bus.in_vld & ~full;
    assign pop  = (dvalid_c & bus.out_rdy) | drop;

    ibuf_fifo #(.DATAW(DATAW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (push),
        .wdata (bus.in_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Dimension-ordered routing: resolve X first, then Y.
    function automatic logic [PORTW:0] xy_route(input logic [DATAW-1:0] f);
        logic [ADDRW-1:0] dx;
        logic [ADDRW-1:0] dy;
        dx = f[2*ADDRW-1:ADDRW];
        dy = f[ADDRW-1:0];
        if (dx > ADDRW'(MYX))      return P_EAST;
        else if (dx < ADDRW'(MYX)) return P_WEST;
        else if (dy > ADDRW'(MYY)) return P_NORTH;
        else if (dy < ADDRW'(MYY)) return P_SOUTH;
        else                       return P_LOCAL;
    endfunction

    assign head_t  = flit_type_e'(head[DATAW-1:DATAW-2]);
    assign is_head = (head_t == FT_HEAD) || (head_t == FT_SINGLE);
    assign is_tail = (head_t == FT_TAIL) || (head_t == FT_SINGLE);

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q <= ST_IDLE;
            port_q  <= P_LOCAL;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        dvalid_c = 1'b0;
        drop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    if (is_head) begin
                        port_d  = xy_route(head);
                        state_d = ST_ROUTE;
                    end
`ifdef IBUF_ERRCHK_EN
                    else begin
                        drop = 1'b1;
                    end
`endif
                end
            end
            // Wait one cycle after grant so the controller's registered select is in place.
            ST_ROUTE: begin
                if (bus.grt) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (!bus.grt) begin
                    state_d = ST_ROUTE;
                end else if (!empty) begin
`ifdef IBUF_ERRCHK_EN
                    if (is_head) begin
                        drop = 1'b1;
                    end else begin
                        dvalid_c = 1'b1;
                        if (bus.out_rdy && is_tail) state_d = ST_IDLE;
                    end
`else
                    dvalid_c = 1'b1;
                    if (bus.out_rdy && is_tail) state_d = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef IBUF_ERRCHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst_) err_q <= 1'b0;
        else      err_q <= drop;
    end

    assign bus.err = err_q;
`endif

    assign bus.in_rdy = ~full;
    assign bus.req    = (state_q != ST_IDLE);
    assign bus.port   = port_q;
    assign bus.dout   = head;
    assign bus.dvalid = dvalid_c;

endmodule

// File: doc/ibuf_route.md
# ibuf_route

Router input-port unit: buffers incoming flits in a small FIFO, computes the XY output port from each head flit, and presents `port`/`req` to the five output-port mux controllers. It drains the packet wormhole-style once granted, and releases the request after the tail flit. One instance sits on each of the five router input ports, directly upstream of the output mux controllers and the crossbar.

## Interface
- `DATAW`, 16: flit width.
  - bits [DATAW-1:DATAW-2] hold the flit type.
  - bits [2*ADDRW-1:0] hold the destination on head flits: X = [2*ADDRW-1:ADDRW], Y = [ADDRW-1:0].
- `ADDRW`, 2: width of each mesh coordinate.
- `MYX`, 0: this router's X coordinate.
- `MYY`, 0: this router's Y coordinate.
- `DEPTH`, 4: FIFO depth in flits; must be a power of 2, minimum 2.
- `clk  input  1`: the only clock.
- `rst_  input  1`: synchronous, active-high reset.
- `in_data  input  DATAW`: flit from the upstream link.
- `in_vld  input  1`: `in_data` is valid.
- `in_rdy  output  1`: FIFO can accept a flit; equals `!full`.
- `port  output  PORTW+1`: destination output port of the current packet.
- `req  output  1`: request to the output mux controllers.
- `grt  input  1`: grant for this input.
  - OR of the `grt[<this input>]` bits from all five output controllers.
- `dout  output  DATAW`: FIFO head flit, routed to the crossbar.
- `dvalid  output  1`: `dout` is transferred this cycle if `out_rdy` is high.
- `out_rdy  input  1`: downstream link can accept a flit.
- `err  output  1`: one-cycle error pulse. Exists only with `IBUF_ERRCHK_EN`.

## Operation
- Flit types: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 SINGLE (head and tail in one flit).
- FIFO:
  - push = `in_vld & in_rdy`; pop = `dvalid & out_rdy`.
  - Count register is log2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, `in_rdy` is low even if a pop occurs that cycle (no pass-through).
- Route computation, XY order, on the head flit:
  - dest X > MYX → East (2); dest X < MYX → West (4).
  - Otherwise dest Y > MYY → North (1); dest Y < MYY → South (3).
  - Otherwise Local (0).
- FSM:
  - IDLE: `req` = 0. If the FIFO is non-empty and the head flit is HEAD or SINGLE, latch the computed port into `port` and go to ROUTE.
  - ROUTE: `req` = 1. On `grt` = 1 go to XFER next cycle; this aligns with the controller's registered `sel`.
  - XFER: `req` = 1 and `dvalid` = `!empty & grt`.
    - On pop of a TAIL or SINGLE flit, go to IDLE; `req` drops the next cycle.
    - If `grt` = 0 while in XFER, return to ROUTE with no pop that cycle.
- `port` holds its latched value from ROUTE until the next head is latched.
- Without `IBUF_ERRCHK_EN`, a BODY or TAIL flit at the FIFO head in IDLE stalls the FIFO indefinitely. This is a protocol violation.

## Timing
- Reset values: FIFO empty, state IDLE, `in_rdy` = 1, `req` = 0, `dvalid` = 0, `port` = 0, `err` = 0. `dout` is don't-care.
- Reset mid-packet discards all buffered flits; `req` is 0 the cycle after reset is sampled.
- Uncontested head pushed at cycle t:
  - IDLE sees it at t+1.
  - ROUTE with `req` = 1 at t+2; `grt` = 1 at t+2.
  - XFER at t+3; first `dout` transfer at t+3 if `out_rdy` = 1.
- Steady state: one flit per cycle while the FIFO is non-empty and `out_rdy` = 1.
- A SINGLE flit occupies XFER for exactly one transfer cycle.

## Configuration
- `IBUF_ERRCHK_EN` defined:
  - In IDLE, a BODY or TAIL flit at the FIFO head is popped and dropped internally; `dvalid` stays 0 and `err` pulses for 1 cycle.
  - In XFER, a HEAD or SINGLE flit at the head is dropped the same way with an `err` pulse; the state is unchanged.
- `IBUF_ERRCHK_EN` undefined: no checking, no `err` port, behaviour as in Operation.

## Structure
- Shared defines file holds:
  - port encodings (LOCAL = 0, N = 1, E = 2, S = 3, W = 4), `PORT`, `PORTW`;
  - flit type codes;
  - FSM state encodings.
- One sub-module, `ibuf_fifo`, provides the parameterized synchronous FIFO with full, empty and count.
- Route compute and FSM live in `ibuf_route`.

## Test plan
- MYX = 1, MYY = 1. Push SINGLE to dest (X = 2, Y = 1) with `grt` tied to `req` → `port` = 2, `req` at t+2, one `dvalid` at t+3, `req` = 0 at t+4.
- 4-flit packet HEAD→(0,1), BODY, BODY, TAIL with `out_rdy` = 1 → `port` = 4, four consecutive transfers, then IDLE.
- Same packet with `out_rdy` low for 2 cycles mid-packet → no flit lost or duplicated, `req` held high throughout.
- Fill FIFO (DEPTH = 4) with `grt` = 0 → `in_rdy` = 0 after the 4th push; a 5th `in_vld` is ignored; order is preserved once `grt` rises.
- Assert `rst_` during XFER with 3 flits buffered → next cycle `req` = 0, `dvalid` = 0, `in_rdy` = 1, FIFO empty.
- With `IBUF_ERRCHK_EN`: BODY flit arrives in IDLE → `err` pulses once, flit is dropped, `req` stays 0.
